// File: rtl/guess_history_display.sv
// guess_history_display: Hangman guess history with duplicate/invalid/full checks driving two LCD rows
module guess_history_display #(
   parameter int NUM_SLOTS = 10,
   parameter int ROW_CHARS = 16,
   parameter int CUR_POS = 7,
   parameter logic [7:0] BLANK = 8'h5F
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   input  logic                             ready,
   input  logic [7:0]                       msg,
   output logic                             busy,
   output logic                             accepted,
   output logic                             dup,
   output logic                             invalid,
   output logic                             rejected,
   output logic                             full,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   count,
   output logic [8*ROW_CHARS-1:0]           row1,
   output logic [8*ROW_CHARS-1:0]           row2
);
   localparam int CW = $clog2(NUM_SLOTS+1);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] MAX = CW'(NUM_SLOTS);
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;
   typedef enum logic [1:0] {R_ACC, R_DUP, R_INV, R_REJ} resp_t;
   state_t state, state_next;
   resp_t resp, resp_next;
   logic [7:0] cur;
   logic [7:0] slots [NUM_SLOTS];
   logic [CW-1:0] idx;
   logic [7:0] norm;
   logic valid;
   assign norm = (msg >= 8'h61 && msg <= 8'h7A) ? msg - 8'h20 : msg;
   assign valid = norm >= 8'h41 && norm <= 8'h5A;
   assign full = count == MAX;
   assign busy = state != IDLE;
   assign accepted = state == RESP && resp == R_ACC;
   assign dup = state == RESP && resp == R_DUP;
   assign invalid = state == RESP && resp == R_INV;
   assign rejected = state == RESP && resp == R_REJ;
   // State and the selected response code
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         resp <= R_ACC;
      end else begin
         state <= state_next;
         resp <= resp_next;
      end
   end
   // Next state: sample guess, scan history one slot per cycle, commit, respond
   always_comb begin
      state_next = state;
      resp_next = resp;
      if (clear) state_next = IDLE;
      else
         case (state)
            IDLE:
               if (ready) begin
                  state_next = !valid ? RESP : (count == '0 ? COMMIT : SCAN);
                  resp_next = R_INV;
               end
            SCAN:
               if (slots[idx] == cur) begin
                  state_next = RESP;
                  resp_next = R_DUP;
               end else if (idx == count - ONE) state_next = COMMIT;
            COMMIT: begin
               state_next = RESP;
               resp_next = full ? R_REJ : R_ACC;
            end
            default: state_next = IDLE;
         endcase
   end
   // Guess capture, scan index and history storage; clear wipes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         cur <= 8'h20;
         idx <= '0;
         count <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= BLANK;
      end else begin
         if (state == IDLE && ready) begin
            cur <= norm;
            idx <= '0;
         end
         if (state == SCAN) idx <= idx + ONE;
         if (state == COMMIT && !full) begin
            slots[count] <= cur;
            count <= count + ONE;
         end
      end
   end
   for (genvar g = 0; g < ROW_CHARS; g++) begin : g_row
      assign row1[8*(ROW_CHARS-g)-1 -: 8] = (g == CUR_POS) ? cur : 8'h20;
      if (g < NUM_SLOTS) begin : g_slot
         assign row2[8*(ROW_CHARS-g)-1 -: 8] = slots[g];
      end else begin : g_pad
         assign row2[8*(ROW_CHARS-g)-1 -: 8] = 8'h20;
      end
   end
endmodule

// File: tb/tb_guess_history_display.sv
// tb_guess_history_display: directed checks of guess_history_display latency, pulses and rows
module tb_guess_history_display;
   logic clk = 0, rst = 1, clear = 0, ready = 0;
   logic [7:0] msg = 8'h00;
   logic busy, accepted, dup, invalid, rejected, full;
   logic [3:0] count;
   logic [127:0] row1, row2;
   int total = 0, bad = 0;
   int k;
   logic [3:0] p;
   logic [7:0] inv_list [5] = '{8'h33, 8'h7B, 8'h60, 8'h40, 8'h5B};

   guess_history_display dut (
      .clk(clk), .rst(rst), .clear(clear), .ready(ready), .msg(msg),
      .busy(busy), .accepted(accepted), .dup(dup), .invalid(invalid), .rejected(rejected),
      .full(full), .count(count), .row1(row1), .row2(row2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // send one guess; k = cycles after sampling edge until a pulse, p = {acc,dup,inv,rej}
   task automatic guess(input logic [7:0] ch, output int kk, output logic [3:0] pp);
      @(negedge clk);
      msg = ch;
      ready = 1;
      @(negedge clk);
      ready = 0;
      kk = 0;
      while (!(accepted | dup | invalid | rejected) && kk < 40) begin
         @(negedge clk);
         kk++;
      end
      pp = {accepted, dup, invalid, rejected};
      @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1;
      @(negedge clk);
      clear = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst_row2", row2, "__________      ");
      check("rst_row1", row1, {16{8'h20}});
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_full", full, 0);
      check("rst_pulses", {accepted, dup, invalid, rejected}, 0);

      guess("e", k, p);
      check("e_k", k, 1);
      check("e_pulse", p, 4'b1000);
      check("e_row1", row1, "       E        ");
      check("e_row2", row2, "E_________      ");
      check("e_count", count, 1);

      do_clear();
      check("clr_count", count, 0);
      guess("A", k, p); check("a_k", k, 1);
      guess("B", k, p); check("b_k", k, 2);
      guess("C", k, p); check("c_k", k, 3); check("c_pulse", p, 4'b1000);
      guess("b", k, p);
      check("dupb_k", k, 2);
      check("dupb_pulse", p, 4'b0100);
      check("dupb_count", count, 3);
      check("dupb_row2", row2, "ABC_______      ");

      foreach (inv_list[i]) begin
         guess(inv_list[i], k, p);
         check("inv_k", k, 0);
         check("inv_pulse", p, 4'b0010);
         check("inv_row1", row1, {{7{8'h20}}, inv_list[i], {8{8'h20}}});
      end
      check("inv_row2", row2, "ABC_______      ");
      check("inv_count", count, 3);

      guess("z", k, p);
      check("z_k", k, 4);
      check("z_pulse", p, 4'b1000);
      check("z_row2", row2, "ABCZ______      ");
      guess("a", k, p);
      check("dupa_k", k, 1);
      check("dupa_pulse", p, 4'b0100);

      do_clear();
      for (int i = 0; i < 10; i++) begin
         guess(8'h41 + 8'(i), k, p);
         check("fill_k", k, i + 1);
         check("fill_pulse", p, 4'b1000);
      end
      check("fill_full", full, 1);
      check("fill_count", count, 10);
      check("fill_row2", row2, "ABCDEFGHIJ      ");
      guess("Q", k, p);
      check("rej_k", k, 11);
      check("rej_pulse", p, 4'b0001);
      check("rej_count", count, 10);
      check("rej_row2", row2, "ABCDEFGHIJ      ");
      guess("j", k, p);
      check("fulldup_k", k, 10);
      check("fulldup_pulse", p, 4'b0100);

      // clear while scanning
      @(negedge clk);
      msg = "Q";
      ready = 1;
      @(negedge clk);
      ready = 0;
      check("scan_busy", busy, 1);
      clear = 1;
      @(negedge clk);
      clear = 0;
      check("midclr_pulses", {accepted, dup, invalid, rejected}, 0);
      check("midclr_busy", busy, 0);
      check("midclr_count", count, 0);
      check("midclr_row2", row2, "__________      ");
      check("midclr_row1", row1, {16{8'h20}});
      p = 0;
      repeat (5) begin
         @(negedge clk);
         p = p | {accepted, dup, invalid, rejected};
      end
      check("midclr_quiet", p, 0);

      // ready while busy is dropped
      guess("A", k, p);
      guess("B", k, p);
      @(negedge clk);
      msg = "C";
      ready = 1;
      @(negedge clk);
      msg = "D";
      @(negedge clk);
      ready = 0;
      k = 0;
      while (!accepted && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("busyc_k", k, 2);
      @(negedge clk);
      p = 0;
      repeat (6) begin
         @(negedge clk);
         p = p | {accepted, dup, invalid, rejected};
      end
      check("busyd_quiet", p, 0);
      check("busyd_count", count, 3);
      check("busyd_row2", row2, "ABC_______      ");
      check("busyd_row1", row1, "       C        ");

      // clear and ready together in IDLE
      @(negedge clk);
      msg = "X";
      ready = 1;
      clear = 1;
      @(negedge clk);
      ready = 0;
      clear = 0;
      check("clrrdy_busy", busy, 0);
      check("clrrdy_count", count, 0);
      check("clrrdy_row1", row1, {16{8'h20}});
      p = 0;
      repeat (4) begin
         @(negedge clk);
         p = p | {accepted, dup, invalid, rejected};
      end
      check("clrrdy_quiet", p, 0);

      // async reset while in COMMIT
      guess("A", k, p);
      @(negedge clk);
      msg = "M";
      ready = 1;
      @(negedge clk);
      ready = 0;
      @(negedge clk);
      check("commit_busy", busy, 1);
      check("commit_count", count, 1);
      #2 rst = 1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_count", count, 0);
      check("arst_row2", row2, "__________      ");
      check("arst_row1", row1, {16{8'h20}});
      check("arst_pulses", {accepted, dup, invalid, rejected}, 0);
      @(negedge clk);
      rst = 0;
      guess("m", k, p);
      check("post_k", k, 1);
      check("post_row2", row2, "M_________      ");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
